// File: rtl/frame_buffer_pkg.sv
// Shared frame-buffer definitions for the write-side and read-side address generators.
// Geometry defaults, memory word type and write-side state encoding.
package frame_buffer_pkg;

  localparam int H_ACTIVE        = 1280;
  localparam int V_ACTIVE        = 720;
  localparam int PIXEL_W         = 16;
  localparam int WORD_PIXELS     = 8;
  localparam int WORDS_PER_FRAME = H_ACTIVE * V_ACTIVE / WORD_PIXELS;
  localparam int ADDR_W          = 27;

  typedef logic [PIXEL_W*WORD_PIXELS-1:0] fb_word_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FULL
  } wr_state_t;

endpackage

// File: rtl/frame_write_address_generator_pixel_packer.sv
// Packs consecutive pixels into one memory word, first pixel in the lowest slot.
// word_done and word are combinational so the word is visible on the cycle its last pixel arrives.
module pixel_packer #(
  parameter int PIXEL_W     = 16,
  parameter int WORD_PIXELS = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear,
  input  logic                           pixel_valid,
  input  logic [PIXEL_W-1:0]             pixel,
  output logic                           word_done,
  output logic [PIXEL_W*WORD_PIXELS-1:0] word
);

  localparam int SLOT_W = (WORD_PIXELS > 1) ? $clog2(WORD_PIXELS) : 1;
  localparam int WORD_W = PIXEL_W * WORD_PIXELS;

  logic [SLOT_W-1:0] slot;
  logic [SLOT_W-1:0] cur_slot;
  logic [WORD_W-1:0] pack_reg;

  // A clear in the same cycle as a pixel makes that pixel slot 0 of a fresh word.
  assign cur_slot  = clear ? '0 : slot;
  assign word_done = pixel_valid && (cur_slot == SLOT_W'(WORD_PIXELS - 1));
  assign word      = {pixel, pack_reg[WORD_W-1:PIXEL_W]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot     <= '0;
      pack_reg <= '0;
    end else if (pixel_valid) begin
      pack_reg <= word;
      slot     <= word_done ? '0 : cur_slot + 1'b1;
    end else if (clear) begin
      slot <= '0;
    end
  end

endmodule

// File: rtl/frame_write_address_generator.sv
// Write side of the DDR frame buffer: packs camera pixels into words and issues them
// with their word address through a single holding register, flagging dropped words.
module frame_write_address_generator #(
  parameter int          H_ACTIVE    = frame_buffer_pkg::H_ACTIVE,
  parameter int          V_ACTIVE    = frame_buffer_pkg::V_ACTIVE,
  parameter int          PIXEL_W     = frame_buffer_pkg::PIXEL_W,
  parameter int          WORD_PIXELS = frame_buffer_pkg::WORD_PIXELS,
  parameter int unsigned BASE_ADDR   = 0
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                frame_start_in,
  input  logic                                pixel_valid_in,
  input  logic [PIXEL_W-1:0]                  pixel_in,
  input  logic                                word_ready_in,
  output logic                                word_valid_out,
  output logic [PIXEL_W*WORD_PIXELS-1:0]      word_data_out,
  output logic [frame_buffer_pkg::ADDR_W-1:0] addr_out,
  output logic                                tlast_out,
  output logic                                overflow_out,
  output logic                                frame_done_out
);

  import frame_buffer_pkg::*;

  localparam int FRAME_WORDS = H_ACTIVE * V_ACTIVE / WORD_PIXELS;
  localparam int IDX_W       = $clog2(FRAME_WORDS + 1);

  wr_state_t                      state;
  wr_state_t                      state_next;
  logic [IDX_W-1:0]               word_idx;
  logic [IDX_W-1:0]               cur_idx;
  logic                           is_last;
  logic                           accept_pixel;
  logic                           word_done;
  logic [PIXEL_W*WORD_PIXELS-1:0] packed_word;
  logic                           handshake;
  logic                           can_load;

  assign accept_pixel = pixel_valid_in && (frame_start_in || state == FILL);
  assign cur_idx      = frame_start_in ? '0 : word_idx;
  assign is_last      = (cur_idx == IDX_W'(FRAME_WORDS - 1));
  assign handshake    = word_valid_out && word_ready_in;
  assign can_load     = !word_valid_out || word_ready_in;

  pixel_packer #(
    .PIXEL_W     (PIXEL_W),
    .WORD_PIXELS (WORD_PIXELS)
  ) u_packer (
    .clk         (clk_in),
    .rst_n       (rst_in),
    .clear       (frame_start_in),
    .pixel_valid (accept_pixel),
    .pixel       (pixel_in),
    .word_done   (word_done),
    .word        (packed_word)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (frame_start_in)        state_next = FILL;
    if (word_done && is_last)  state_next = FULL;
  end

  // Index advances even when the word is dropped so later addresses stay aligned with memory.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      word_idx       <= '0;
      word_valid_out <= 1'b0;
      word_data_out  <= '0;
      addr_out       <= '0;
      tlast_out      <= 1'b0;
      overflow_out   <= 1'b0;
      frame_done_out <= 1'b0;
    end else begin
      frame_done_out <= handshake && tlast_out;
      if (word_done)           word_idx <= cur_idx + 1'b1;
      else if (frame_start_in) word_idx <= '0;
      if (frame_start_in) overflow_out <= 1'b0;
      if (handshake)      word_valid_out <= 1'b0;
      if (word_done) begin
        if (can_load) begin
          word_valid_out <= 1'b1;
          word_data_out  <= packed_word;
          addr_out       <= ADDR_W'(BASE_ADDR) + ADDR_W'(cur_idx);
          tlast_out      <= is_last;
        end else begin
          overflow_out <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_write_address_generator.sv
// Directed bench for the frame write address generator using a 16x2 frame (4 words).
// Accepted words are logged on the falling edge and checked per scenario.
module tb_frame_write_address_generator;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic         frame_start_in;
  logic         pixel_valid_in;
  logic [15:0]  pixel_in;
  logic         word_ready_in;
  logic         word_valid_out;
  logic [127:0] word_data_out;
  logic [26:0]  addr_out;
  logic         tlast_out;
  logic         overflow_out;
  logic         frame_done_out;

  logic [127:0] acc_data[$];
  logic [26:0]  acc_addr[$];
  logic         acc_last[$];
  int           done_cnt;
  int           valid_cnt;
  int           tests;
  int           failures;

  always #5 clk_in = ~clk_in;

  frame_write_address_generator #(
    .H_ACTIVE    (16),
    .V_ACTIVE    (2),
    .PIXEL_W     (16),
    .WORD_PIXELS (8),
    .BASE_ADDR   (0)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .frame_start_in (frame_start_in),
    .pixel_valid_in (pixel_valid_in),
    .pixel_in       (pixel_in),
    .word_ready_in  (word_ready_in),
    .word_valid_out (word_valid_out),
    .word_data_out  (word_data_out),
    .addr_out       (addr_out),
    .tlast_out      (tlast_out),
    .overflow_out   (overflow_out),
    .frame_done_out (frame_done_out)
  );

  always @(negedge clk_in) begin
    if (rst_in) begin
      if (word_valid_out) valid_cnt++;
      if (word_valid_out && word_ready_in) begin
        acc_data.push_back(word_data_out);
        acc_addr.push_back(addr_out);
        acc_last.push_back(tlast_out);
      end
      if (frame_done_out) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_log();
    acc_data.delete();
    acc_addr.delete();
    acc_last.delete();
    done_cnt  = 0;
    valid_cnt = 0;
  endtask

  task automatic start_frame();
    frame_start_in = 1'b1;
    tick();
    frame_start_in = 1'b0;
  endtask

  task automatic send_pixels(input logic [15:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      pixel_valid_in = 1'b1;
      pixel_in       = first + 16'(i);
      tick();
    end
    pixel_valid_in = 1'b0;
  endtask

  function automatic logic [127:0] make_word(input logic [15:0] first);
    logic [127:0] w;
    for (int j = 0; j < 8; j++) w[j*16 +: 16] = first + 16'(j);
    return w;
  endfunction

  task automatic test_reset();
    rst_in = 1'b0;
    repeat (2) tick();
    tests++;
    if ({word_valid_out, word_data_out, addr_out, tlast_out, overflow_out, frame_done_out} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: valid=%0b addr=%0d tlast=%0b ovf=%0b done=%0b data=%h, required all 0",
               word_valid_out, addr_out, tlast_out, overflow_out, frame_done_out, word_data_out);
    end
    rst_in = 1'b1;
    tick();
  endtask

  task automatic test_basic_frame();
    logic [127:0] w0;
    w0 = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
    word_ready_in = 1'b1;
    clear_log();
    start_frame();
    send_pixels(16'h0000, 32);
    repeat (3) tick();
    tests++;
    if (acc_addr.size() !== 4) begin
      failures++;
      $display("[TB] FAIL basic_count: got %0d words, required 4", acc_addr.size());
    end
    for (int k = 0; k < 4 && k < acc_addr.size(); k++) begin
      tests++;
      if (acc_addr[k] !== 27'(k) || acc_data[k] !== make_word(16'(8*k)) || acc_last[k] !== (k == 3)) begin
        failures++;
        $display("[TB] FAIL basic_word[%0d]: addr=%0d last=%0b data=%h, required addr=%0d last=%0b data=%h",
                 k, acc_addr[k], acc_last[k], acc_data[k], k, (k == 3), make_word(16'(8*k)));
      end
    end
    tests++;
    if (acc_data.size() == 0 || acc_data[0] !== w0) begin
      failures++;
      $display("[TB] FAIL basic_word0_literal: got %h, required %h", (acc_data.size() > 0) ? acc_data[0] : '0, w0);
    end
    tests++;
    if (done_cnt !== 1 || overflow_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_done_ovf: done pulses=%0d ovf=%0b, required 1 and 0", done_cnt, overflow_out);
    end
  endtask

  task automatic test_overflow();
    logic [26:0] exp_addr [3];
    exp_addr = '{27'd0, 27'd2, 27'd3};
    clear_log();
    word_ready_in = 1'b0;
    start_frame();
    for (int i = 0; i < 32; i++) begin
      pixel_valid_in = 1'b1;
      pixel_in       = 16'(i);
      if (i == 20) word_ready_in = 1'b1;
      tick();
      if (i == 12 || i == 19) begin
        tests++;
        if (word_valid_out !== 1'b1 || word_data_out !== make_word(16'h0000) || addr_out !== 27'd0) begin
          failures++;
          $display("[TB] FAIL ovf_hold[%0d]: valid=%0b addr=%0d data=%h, required 1, 0, %h",
                   i, word_valid_out, addr_out, word_data_out, make_word(16'h0000));
        end
      end
    end
    pixel_valid_in = 1'b0;
    repeat (3) tick();
    tests++;
    if (acc_addr.size() !== 3) begin
      failures++;
      $display("[TB] FAIL ovf_count: got %0d words, required 3", acc_addr.size());
    end
    for (int k = 0; k < 3 && k < acc_addr.size(); k++) begin
      tests++;
      if (acc_addr[k] !== exp_addr[k] || acc_last[k] !== (k == 2)) begin
        failures++;
        $display("[TB] FAIL ovf_word[%0d]: addr=%0d last=%0b, required addr=%0d last=%0b",
                 k, acc_addr[k], acc_last[k], exp_addr[k], (k == 2));
      end
    end
    tests++;
    if (acc_data.size() < 2 || acc_data[1] !== make_word(16'h0010)) begin
      failures++;
      $display("[TB] FAIL ovf_word2_data: got %h, required %h",
               (acc_data.size() > 1) ? acc_data[1] : '0, make_word(16'h0010));
    end
    tests++;
    if (overflow_out !== 1'b1 || done_cnt !== 1) begin
      failures++;
      $display("[TB] FAIL ovf_flag: ovf=%0b done pulses=%0d, required 1 and 1", overflow_out, done_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    word_ready_in = 1'b1;
    start_frame();
    send_pixels(16'h0040, 5);
    #2;
    rst_in = 1'b0;
    #1;
    tests++;
    if ({word_valid_out, word_data_out, addr_out, tlast_out, overflow_out, frame_done_out} !== '0) begin
      failures++;
      $display("[TB] FAIL async_reset: valid=%0b addr=%0d tlast=%0b ovf=%0b done=%0b, required all 0",
               word_valid_out, addr_out, tlast_out, overflow_out, frame_done_out);
    end
    tick();
    rst_in = 1'b1;
    tick();
    clear_log();
    start_frame();
    send_pixels(16'h0100, 8);
    repeat (2) tick();
    tests++;
    if (acc_addr.size() !== 1 || acc_addr[0] !== 27'd0 || acc_data[0] !== make_word(16'h0100)) begin
      failures++;
      $display("[TB] FAIL restart_word: count=%0d addr=%0d data=%h, required 1, 0, %h", acc_addr.size(),
               (acc_addr.size() > 0) ? acc_addr[0] : '0, (acc_data.size() > 0) ? acc_data[0] : '0,
               make_word(16'h0100));
    end
  endtask

  task automatic test_short_frame();
    logic [127:0] exp_data [5];
    logic [26:0]  exp_addr [5];
    exp_data = '{make_word(16'h0200), make_word(16'h0300), make_word(16'h0308),
                 make_word(16'h0310), make_word(16'h0318)};
    exp_addr = '{27'd0, 27'd0, 27'd1, 27'd2, 27'd3};
    clear_log();
    word_ready_in = 1'b0;
    start_frame();
    send_pixels(16'h0200, 11);
    start_frame();
    word_ready_in = 1'b1;
    send_pixels(16'h0300, 32);
    repeat (3) tick();
    tests++;
    if (acc_addr.size() !== 5) begin
      failures++;
      $display("[TB] FAIL short_count: got %0d words, required 5", acc_addr.size());
    end
    for (int k = 0; k < 5 && k < acc_addr.size(); k++) begin
      tests++;
      if (acc_addr[k] !== exp_addr[k] || acc_data[k] !== exp_data[k] || acc_last[k] !== (k == 4)) begin
        failures++;
        $display("[TB] FAIL short_word[%0d]: addr=%0d last=%0b data=%h, required addr=%0d last=%0b data=%h",
                 k, acc_addr[k], acc_last[k], acc_data[k], exp_addr[k], (k == 4), exp_data[k]);
      end
    end
    tests++;
    if (done_cnt !== 1) begin
      failures++;
      $display("[TB] FAIL short_done: got %0d pulses, required 1", done_cnt);
    end
  endtask

  task automatic test_start_with_pixel();
    logic [127:0] w0;
    w0        = make_word(16'h0000);
    w0[15:0]  = 16'hABCD;
    clear_log();
    word_ready_in  = 1'b1;
    frame_start_in = 1'b1;
    pixel_valid_in = 1'b1;
    pixel_in       = 16'hABCD;
    tick();
    frame_start_in = 1'b0;
    send_pixels(16'h0001, 31);
    repeat (3) tick();
    tests++;
    if (acc_data.size() == 0 || acc_data[0][15:0] !== 16'hABCD || acc_data[0] !== w0 || acc_addr[0] !== 27'd0) begin
      failures++;
      $display("[TB] FAIL start_pixel_word0: data=%h addr=%0d, required %h at 0",
               (acc_data.size() > 0) ? acc_data[0] : '0, (acc_addr.size() > 0) ? acc_addr[0] : '0, w0);
    end
    tests++;
    if (acc_last.size() !== 4 || acc_last[3] !== 1'b1 || done_cnt !== 1) begin
      failures++;
      $display("[TB] FAIL start_pixel_frame: words=%0d done=%0d, required 4 words ending in tlast, 1 done",
               acc_last.size(), done_cnt);
    end
  endtask

  task automatic test_extra_pixels();
    clear_log();
    send_pixels(16'h0500, 8);
    repeat (3) tick();
    tests++;
    if (valid_cnt !== 0 || acc_addr.size() !== 0) begin
      failures++;
      $display("[TB] FAIL extra_pixels_ignored: valid cycles=%0d words=%0d, required 0 and 0",
               valid_cnt, acc_addr.size());
    end
    start_frame();
    send_pixels(16'h0600, 8);
    repeat (2) tick();
    tests++;
    if (acc_addr.size() !== 1 || acc_addr[0] !== 27'd0 || acc_data[0] !== make_word(16'h0600)) begin
      failures++;
      $display("[TB] FAIL extra_next_frame: count=%0d addr=%0d data=%h, required 1, 0, %h", acc_addr.size(),
               (acc_addr.size() > 0) ? acc_addr[0] : '0, (acc_data.size() > 0) ? acc_data[0] : '0,
               make_word(16'h0600));
    end
  endtask

  initial begin
    tests          = 0;
    failures       = 0;
    rst_in         = 1'b0;
    frame_start_in = 1'b0;
    pixel_valid_in = 1'b0;
    pixel_in       = '0;
    word_ready_in  = 1'b1;
    clear_log();
    test_reset();
    test_basic_frame();
    test_overflow();
    test_reset_mid_frame();
    test_short_frame();
    test_start_with_pixel();
    test_extra_pixels();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/frame_write_address_generator.md
Name: frame_write_address_generator

Overview:
- Write side of the DDR frame buffer: takes the camera pixel stream, packs pixels into 128-bit memory words, and issues each word with its frame-buffer word address.
- Asserts tlast on the final word of every frame, matching the frame-end marker convention used by the zoomed read-side address generator.
- Sits between the camera pixel pipeline and the write FIFO feeding the DDR controller.

Parameters:
- H_ACTIVE, 1280, active pixels per row.
- V_ACTIVE, 720, active rows per frame.
- PIXEL_W, 16, bits per pixel (RGB565).
- WORD_PIXELS, 8, pixels per memory word; must divide H_ACTIVE.
- BASE_ADDR, 0, word address of pixel (0,0).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-low reset.
- frame_start_in  input  1  single-cycle pulse at camera frame start.
- pixel_valid_in  input  1  pixel_in valid this cycle; the block never stalls pixel input.
- pixel_in  input  PIXEL_W  pixel data, raster order.
- word_ready_in  input  1  downstream FIFO accepts the word.
- word_valid_out  output  1  word_data_out, addr_out and tlast_out are valid.
- word_data_out  output  PIXEL_W*WORD_PIXELS  packed word.
- addr_out  output  27  word address, BASE_ADDR + word index.
- tlast_out  output  1  high with the last word of the frame.
- overflow_out  output  1  sticky; a completed word was dropped.
- frame_done_out  output  1  one-cycle pulse when the tlast word is accepted.

Behaviour:
- Reset (rst_in low, asynchronous): all outputs 0; pixel count, word index and slot count cleared; state IDLE.
- States:
  - IDLE: pixels are ignored until frame_start_in.
  - FILL: pixels are packed.
  - FULL: all H_ACTIVE*V_ACTIVE pixels are in; further pixels are ignored until the next frame_start_in.
- Packing:
  - First pixel of each word goes in bits [PIXEL_W-1:0]; slot k goes in bits [(k+1)*PIXEL_W-1 : k*PIXEL_W].
  - Slot counter wraps 0..WORD_PIXELS-1.
- Output register: a single-entry holding register.
  - word_valid_out rises on the cycle after the WORD_PIXELS-th pixel is sampled (latency 1).
  - The word is held stable until word_valid_out and word_ready_in are both high.
  - A completed word that arrives in the same cycle as acceptance of the previous word is loaded with no bubble.
- Overflow:
  - A word completes while the register holds an unaccepted word: the new word is dropped and overflow_out is set.
  - The word index still advances, so later addresses stay correct.
  - overflow_out clears only on frame_start_in or reset.
- Addressing:
  - Word index runs 0..(H_ACTIVE*V_ACTIVE/WORD_PIXELS)-1.
  - addr_out = BASE_ADDR + index, 27-bit, wrapping modulo 2^27.
  - tlast_out is set only with index = last; the state then moves to FULL.
- frame_start_in:
  - Clears the slot count, word index and overflow, and discards any partial word.
  - State becomes FILL.
  - A pending output word is kept, with its original address and tlast.
- frame_start_in and pixel_valid_in in the same cycle: the pixel becomes slot 0, index 0 of the new frame.
- frame_start_in during FILL (short frame): the frame is abandoned silently; no tlast is issued.
- frame_done_out pulses the cycle after the handshake on a tlast word.

Decomposition:
- frame_buffer_pkg holds:
  - constants H_ACTIVE, V_ACTIVE, PIXEL_W, WORD_PIXELS;
  - WORDS_PER_FRAME;
  - ADDR_W = 27;
  - typedef fb_word_t;
  - enum wr_state_t {IDLE, FILL, FULL}.
- The read-side address generator shares the same package.
- One sub-module, pixel_packer: slot counter plus shift/pack register, emitting word_done and the word.
- Top level holds the state machine, word index, holding register and overflow logic.

Test Plan:
- H_ACTIVE=16, V_ACTIVE=2, ready tied high; frame_start, then 32 consecutive pixels 0x0000..0x001F:
  - 4 words at addr 0..3;
  - word0 = 0x0007_0006_0005_0004_0003_0002_0001_0000;
  - tlast only on addr 3; frame_done_out pulses once.
- Same stimulus with word_ready_in low for 12 cycles after the first word:
  - word 1 is dropped and overflow_out=1;
  - word 0 is held stable, then accepted;
  - next accepted address is 2.
- Assert rst_in low mid-frame after 5 pixels, release, then frame_start:
  - all outputs are 0 immediately (asynchronous);
  - the first word after restart has addr 0 and holds the new pixels only.
- frame_start after 11 pixels:
  - the 3 partial pixels are discarded;
  - the pending word at addr 0 is still delivered;
  - the new frame starts at addr 0 with no tlast on the abandoned frame.
- frame_start and pixel_valid in the same cycle with pixel 0xABCD: word0[15:0]=0xABCD at addr 0.
- Extra 8 pixels after the tlast word: no word_valid_out until the next frame_start.
